gcd_controller: RTL and testbench

Control unit for the GCD datapath. It sequences the Euclidean algorithm by driving the datapath's write-back flags, register-transfer selects, ALU mode and modulo handshake. It observes the datapath's `modulo_ready` and `valid` returns, and reports `busy`/`done`/`error` to the top level. It sits beside the datapath in the GCD top, one port-to-port connection per control line.

---
 rtl/gcd_controller.sv | 196 +++++++++++++++++++
 tb/tb_gcd_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// gcd_controller: control unit that sequences the Euclidean GCD algorithm on
// the companion datapath.
// Ports:
//   clk, rst_i (async, active-low)
//   start_i          - start request, sampled in IDLE only
//   modulo_ready_i   - ALU modulo result valid
//   valid_i          - datapath termination flag (remainder == 0 during check)
//   alu_mode_o       - ALU mode select (NOP/MAX/MIN/MOD)
//   modulo_start_o   - one-cycle modulo start pulse
//   wren_*_o         - datapath write-back flags
//   Zahl1_to_alu_a_o, Zahl2_to_alu_b_o - operand-to-ALU selects
//   check_for_termination_o - enables datapath valid
//   busy_o, done_o, error_o - status to top level
module gcd_controller (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       modulo_ready_i,
    input  logic       valid_i,
    output logic [2:0] alu_mode_o,
    output logic       modulo_start_o,
    output logic       wren_initial_o,
    output logic       wren_zw_gross_o,
    output logic       wren_zw_klein_o,
    output logic       wren_zw_in_zahlen_o,
    output logic       wren_erg_modulo_o,
    output logic       wren_Zahl_o,
    output logic       wren_to_new_numbers_o,
    output logic       Zahl1_to_alu_a_o,
    output logic       Zahl2_to_alu_b_o,
    output logic       check_for_termination_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam logic [2:0]  MODE_NOP    = 3'd0;
    localparam logic [2:0]  MODE_MAX    = 3'd1;
    localparam logic [2:0]  MODE_MIN    = 3'd2;
    localparam logic [2:0]  MODE_MOD    = 3'd3;
    localparam int unsigned MOD_TIMEOUT = 64;
    localparam int unsigned MAX_ITER    = 32;
    localparam int unsigned TMO_W       = $clog2(MOD_TIMEOUT);
    localparam int unsigned ITER_W      = $clog2(MAX_ITER + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_MAX, S_MAX_WB, S_MIN_WB, S_SWAP, S_MOD_START,
        S_MOD_WAIT, S_MOD_WB, S_CHECK, S_UPDATE, S_DONE, S_ERROR
    } state_t;

    typedef struct packed {
        logic [2:0] alu_mode;
        logic       modulo_start;
        logic       wren_initial;
        logic       wren_zw_gross;
        logic       wren_zw_klein;
        logic       wren_zw_in_zahlen;
        logic       wren_erg_modulo;
        logic       wren_zahl;
        logic       wren_to_new_numbers;
        logic       sel_a;
        logic       sel_b;
        logic       check;
        logic       busy;
        logic       done;
        logic       error;
    } ctrl_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ITER_W-1:0]   r_iter_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    ctrl_t               r_ctrl;
    ctrl_t               w_ctrl;

    // State, counters and output register. Outputs are decoded from the next
    // state and registered, so they follow the state register cycle-for-cycle
    // and clear together with it on asynchronous reset.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_iter_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_ctrl     <= '0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= w_ctrl;
            case (r_state)
                S_SWAP: r_iter_cnt <= '0;
                S_MOD_START: begin
                    if (r_iter_cnt != ITER_W'(MAX_ITER))
                        r_iter_cnt <= r_iter_cnt + ITER_W'(1);
                    r_tmo_cnt <= '0;
                end
                S_MOD_WAIT: begin
                    if (!modulo_ready_i && (r_tmo_cnt != TMO_W'(MOD_TIMEOUT - 1)))
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:      if (start_i) w_state_next = S_LOAD;
            S_LOAD:      w_state_next = S_MAX;
            S_MAX:       w_state_next = S_MAX_WB;
            S_MAX_WB:    w_state_next = S_MIN_WB;
            S_MIN_WB:    w_state_next = S_SWAP;
            S_SWAP:      w_state_next = S_MOD_START;
            S_MOD_START: w_state_next = S_MOD_WAIT;
            S_MOD_WAIT: begin
                if (modulo_ready_i)
                    w_state_next = S_MOD_WB;
                else if (r_tmo_cnt == TMO_W'(MOD_TIMEOUT - 1))
                    w_state_next = S_ERROR;
            end
            S_MOD_WB:    w_state_next = S_CHECK;
            S_CHECK: begin
                if (valid_i)
                    w_state_next = S_DONE;
                else if (r_iter_cnt == ITER_W'(MAX_ITER))
                    w_state_next = S_ERROR;
                else
                    w_state_next = S_UPDATE;
            end
            S_UPDATE:    w_state_next = S_MOD_START;
            S_DONE:      w_state_next = S_IDLE;
            S_ERROR:     w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state.
    always_comb begin
        w_ctrl          = '0;
        w_ctrl.alu_mode = MODE_NOP;
        w_ctrl.busy     = (w_state_next != S_IDLE);
        unique case (w_state_next)
            S_LOAD:      w_ctrl.wren_initial = 1'b1;
            S_MAX: begin
                w_ctrl.sel_a    = 1'b1;
                w_ctrl.sel_b    = 1'b1;
                w_ctrl.alu_mode = MODE_MAX;
            end
            S_MAX_WB: begin
                w_ctrl.wren_zw_gross = 1'b1;
                w_ctrl.sel_a         = 1'b1;
                w_ctrl.sel_b         = 1'b1;
                w_ctrl.alu_mode      = MODE_MIN;
            end
            S_MIN_WB:    w_ctrl.wren_zw_klein     = 1'b1;
            S_SWAP:      w_ctrl.wren_zw_in_zahlen = 1'b1;
            S_MOD_START: begin
                w_ctrl.modulo_start = 1'b1;
                w_ctrl.sel_a        = 1'b1;
                w_ctrl.sel_b        = 1'b1;
                w_ctrl.alu_mode     = MODE_MOD;
            end
            S_MOD_WAIT: begin
                w_ctrl.sel_a    = 1'b1;
                w_ctrl.sel_b    = 1'b1;
                w_ctrl.alu_mode = MODE_MOD;
            end
            S_MOD_WB:    w_ctrl.wren_erg_modulo = 1'b1;
            S_CHECK:     w_ctrl.check           = 1'b1;
            S_UPDATE: begin
                w_ctrl.wren_zahl           = 1'b1;
                w_ctrl.wren_to_new_numbers = 1'b1;
            end
            S_DONE:      w_ctrl.done  = 1'b1;
            S_ERROR:     w_ctrl.error = 1'b1;
            default: ;
        endcase
    end

    assign alu_mode_o              = r_ctrl.alu_mode;
    assign modulo_start_o          = r_ctrl.modulo_start;
    assign wren_initial_o          = r_ctrl.wren_initial;
    assign wren_zw_gross_o         = r_ctrl.wren_zw_gross;
    assign wren_zw_klein_o         = r_ctrl.wren_zw_klein;
    assign wren_zw_in_zahlen_o     = r_ctrl.wren_zw_in_zahlen;
    assign wren_erg_modulo_o       = r_ctrl.wren_erg_modulo;
    assign wren_Zahl_o             = r_ctrl.wren_zahl;
    assign wren_to_new_numbers_o   = r_ctrl.wren_to_new_numbers;
    assign Zahl1_to_alu_a_o        = r_ctrl.sel_a;
    assign Zahl2_to_alu_b_o        = r_ctrl.sel_b;
    assign check_for_termination_o = r_ctrl.check;
    assign busy_o                  = r_ctrl.busy;
    assign done_o                  = r_ctrl.done;
    assign error_o                 = r_ctrl.error;

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed bench for gcd_controller with a small
// behavioural datapath model driven from the controller's outputs.
module tb_gcd_controller;

    localparam int M_NOP = 0;
    localparam int M_MAX = 1;
    localparam int M_MIN = 2;
    localparam int M_MOD = 3;
    localparam int TMO   = 64;

    logic       clk;
    logic       rst_i;
    logic       start_i;
    logic       modulo_ready_i;
    logic       valid_i;
    logic [2:0] alu_mode_o;
    logic       modulo_start_o;
    logic       wren_initial_o;
    logic       wren_zw_gross_o;
    logic       wren_zw_klein_o;
    logic       wren_zw_in_zahlen_o;
    logic       wren_erg_modulo_o;
    logic       wren_Zahl_o;
    logic       wren_to_new_numbers_o;
    logic       Zahl1_to_alu_a_o;
    logic       Zahl2_to_alu_b_o;
    logic       check_for_termination_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    logic [16:0] w_outs;
    int          checks;
    int          failures;

    assign w_outs = {alu_mode_o, modulo_start_o, wren_initial_o, wren_zw_gross_o,
                     wren_zw_klein_o, wren_zw_in_zahlen_o, wren_erg_modulo_o,
                     wren_Zahl_o, wren_to_new_numbers_o, Zahl1_to_alu_a_o,
                     Zahl2_to_alu_b_o, check_for_termination_o, busy_o, done_o, error_o};

    gcd_controller dut (
        .clk                     (clk),
        .rst_i                   (rst_i),
        .start_i                 (start_i),
        .modulo_ready_i          (modulo_ready_i),
        .valid_i                 (valid_i),
        .alu_mode_o              (alu_mode_o),
        .modulo_start_o          (modulo_start_o),
        .wren_initial_o          (wren_initial_o),
        .wren_zw_gross_o         (wren_zw_gross_o),
        .wren_zw_klein_o         (wren_zw_klein_o),
        .wren_zw_in_zahlen_o     (wren_zw_in_zahlen_o),
        .wren_erg_modulo_o       (wren_erg_modulo_o),
        .wren_Zahl_o             (wren_Zahl_o),
        .wren_to_new_numbers_o   (wren_to_new_numbers_o),
        .Zahl1_to_alu_a_o        (Zahl1_to_alu_a_o),
        .Zahl2_to_alu_b_o        (Zahl2_to_alu_b_o),
        .check_for_termination_o (check_for_termination_o),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .error_o                 (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One run, driven from a negedge with the DUT idle. Cycle k is the k-th
    // cycle after the start edge. w = ALU ready latency in wait cycles
    // (0 = never ready). abort_at != 0 drops reset mid-cycle at that cycle.
    task automatic run_gcd(input int a, input int b, input int w, input bit hold,
                           input bit stray, input int abort_at,
                           output int done_cyc, output int err_cyc, output int first_mod,
                           output int n_mod, output int n_upd, output int n_load,
                           output int n_viol, output int result);
        int cyc, wcnt, z1, z2, gross, klein, erg, groups;
        bit fin;
        done_cyc = -1; err_cyc = -1; first_mod = -1;
        n_mod = 0; n_upd = 0; n_load = 0; n_viol = 0; result = -1;
        z1 = 0; z2 = 0; gross = 0; klein = 0; erg = -1; wcnt = 0;
        cyc = 0; fin = 1'b0;
        check_eq("idle_busy", int'(busy_o), 0);
        start_i = 1'b1;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!hold) start_i = 1'b0;
            modulo_ready_i = 1'b0;
            valid_i        = 1'b0;
            if (cyc == 1) check_eq("busy_rise", int'(busy_o), 1);
            if (cyc == 2) check_eq("max_state", int'({alu_mode_o, Zahl1_to_alu_a_o, Zahl2_to_alu_b_o}), (M_MAX << 2) | 3);
            if (cyc == 3) check_eq("max_wb_state", int'({alu_mode_o, wren_zw_gross_o}), (M_MIN << 1) | 1);
            if (abort_at != 0 && cyc == abort_at) begin
                check_eq("abort_in_wait", int'(alu_mode_o), M_MOD);
                #2 rst_i = 1'b0;
                #1;
                check_eq("reset_async_outs", int'(w_outs), 0);
                check_eq("reset_async_busy", int'(busy_o), 0);
                fin = 1'b1;
            end else begin
                if (modulo_start_o) begin
                    n_mod++;
                    wcnt = 0;
                    if (first_mod < 0) first_mod = cyc;
                end else if (int'(alu_mode_o) == M_MOD) begin
                    wcnt++;
                    if (w > 0 && wcnt == w) modulo_ready_i = 1'b1;
                end
                if (stray && (check_for_termination_o || wren_Zahl_o)) modulo_ready_i = 1'b1;
                if (check_for_termination_o) valid_i = (erg == 0);
                groups = int'(wren_initial_o) + int'(wren_zw_in_zahlen_o)
                       + int'(wren_Zahl_o || wren_to_new_numbers_o);
                if (groups > 1) n_viol++;
                if (wren_Zahl_o != wren_to_new_numbers_o) n_viol++;
                if (wren_initial_o) begin n_load++; z1 = a; z2 = b; end
                if (wren_zw_gross_o) gross = (z1 > z2) ? z1 : z2;
                if (wren_zw_klein_o) klein = (z1 < z2) ? z1 : z2;
                if (wren_zw_in_zahlen_o) begin z1 = gross; z2 = klein; end
                if (wren_erg_modulo_o) erg = (z2 != 0) ? z1 % z2 : 0;
                if (wren_Zahl_o) begin n_upd++; z1 = z2; z2 = erg; end
                if (done_o) begin done_cyc = cyc; result = z2; fin = 1'b1; end
                if (error_o) begin err_cyc = cyc; fin = 1'b1; end
            end
        end
        if (!fin) check_eq("run_bound", 0, 1);
    endtask

    initial begin
        int dc, ec, fm, nm, nu, nl, nv, res;
        checks = 0; failures = 0;
        rst_i = 1'b0; start_i = 1'b1; modulo_ready_i = 1'b0; valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", int'(w_outs), 0);
        check_eq("reset_mode", int'(alu_mode_o), M_NOP);
        start_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("post_reset_idle", int'(busy_o), 0);

        // 48,18 with W=2: three modulo passes, two updates.
        run_gcd(48, 18, 2, 1'b0, 1'b0, 0, dc, ec, fm, nm, nu, nl, nv, res);
        check_eq("a_done_cyc", dc, 23);
        check_eq("a_mod_cnt", nm, 3);
        check_eq("a_upd_cnt", nu, 2);
        check_eq("a_first_mod", fm, 6);
        check_eq("a_result", res, 6);
        check_eq("a_no_error", ec, -1);
        check_eq("a_wren_excl", nv, 0);
        @(negedge clk);
        check_eq("a_busy_fall", int'(busy_o), 0);

        // Swapped operands behave identically.
        run_gcd(18, 48, 2, 1'b0, 1'b0, 0, dc, ec, fm, nm, nu, nl, nv, res);
        check_eq("b_done_cyc", dc, 23);
        check_eq("b_mod_cnt", nm, 3);
        check_eq("b_upd_cnt", nu, 2);
        check_eq("b_result", res, 6);
        check_eq("b_no_error", ec, -1);
        @(negedge clk);

        // Equal operands: single pass, no update.
        run_gcd(7, 7, 2, 1'b0, 1'b0, 0, dc, ec, fm, nm, nu, nl, nv, res);
        check_eq("c_done_cyc", dc, 11);
        check_eq("c_mod_cnt", nm, 1);
        check_eq("c_upd_cnt", nu, 0);
        check_eq("c_result", res, 7);
        @(negedge clk);

        // ALU never ready: 64 wait cycles between MOD_START and ERROR.
        run_gcd(48, 18, 0, 1'b0, 1'b0, 0, dc, ec, fm, nm, nu, nl, nv, res);
        check_eq("t_err_delay", ec - fm, TMO + 1);
        check_eq("t_err_cyc", ec, 6 + TMO + 1);
        check_eq("t_no_done", dc, -1);
        check_eq("t_mod_cnt", nm, 1);
        @(negedge clk);
        check_eq("t_back_idle", int'(w_outs), 0);

        // start held high throughout, stray ready pulses outside MOD_WAIT.
        run_gcd(48, 18, 2, 1'b1, 1'b1, 0, dc, ec, fm, nm, nu, nl, nv, res);
        check_eq("h_done_cyc", dc, 23);
        check_eq("h_load_cnt", nl, 1);
        check_eq("h_mod_cnt", nm, 3);
        check_eq("h_result", res, 6);
        @(negedge clk);
        check_eq("h_idle_after_done", int'(busy_o), 0);
        @(negedge clk);
        check_eq("h_restart_load", int'({busy_o, wren_initial_o}), 3);
        start_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        // Asynchronous reset in MOD_WAIT, then a clean run.
        run_gcd(48, 18, 0, 1'b0, 1'b0, 7, dc, ec, fm, nm, nu, nl, nv, res);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("r_idle_after_release", int'(busy_o), 0);
        run_gcd(48, 18, 2, 1'b0, 1'b0, 0, dc, ec, fm, nm, nu, nl, nv, res);
        check_eq("r_done_cyc", dc, 23);
        check_eq("r_result", res, 6);
        check_eq("r_no_error", ec, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
